// File: rtl/imem_loader_ctrl.sv
// Boot loader: parses a little-endian word-count header from the UART byte stream,
// packs payload bytes into 32-bit instruction-memory writes and holds the core until done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 16346
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;
`endif

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       MAX_N  = 32'(MAX_WORDS);
  localparam logic [ADDR_W:0]   WL_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         buf_q, buf_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic [31:0]         cur_word;
  logic [ADDR_W:0]     wl_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    n_d      = n_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    wl_d     = wl_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    // The byte arriving now completes the little-endian word held in buf_q.
    cur_word = {rx_data, buf_q};
    wl_inc   = wl_q + WL_ONE;

    case (state_q)
      S_HDR: begin
        if (rx_valid) begin
          buf_d = {rx_data, buf_q[23:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (cur_word > MAX_N) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else if (cur_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end else begin
              state_d = S_LOAD;
              n_d     = cur_word[ADDR_W:0];
            end
          end
        end
      end

      S_LOAD: begin
        if (rx_valid) begin
          buf_d = {rx_data, buf_q[23:8]};
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = BASE_A + wl_q[ADDR_W-1:0];
            wdata_d = cur_word;
            wl_d    = wl_inc;
            // Release waits one cycle in DONE so the final write is retired first.
            if (wl_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      S_DONE: begin
        done_d = 1'b1;
        hold_d = 1'b0;
      end

      S_ERR: begin
        err_d  = 1'b1;
        hold_d = 1'b1;
      end

      default: state_d = S_HDR;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      idx_q   <= 2'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wl_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Byte assembly and word count; always fully refilled before use after reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    n_q   <= n_d;
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_hold    = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Testbench for imem_loader_ctrl: directed byte streams against a stream-level model
// that predicts every write, its cycle, and the done/error cycles.
module tb_imem_loader_ctrl;
  localparam int ADDR_W    = 14;
  localparam int BASE_ADDR = 0;
  localparam int MAX_WORDS = 16346;
  localparam int INF       = 32'h7fffffff;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader_ctrl #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                c;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  int         obs[$];
  logic [7:0] stim[$];
  int         done_cyc = INF;
  int         err_cyc  = INF;
  bit         chk_en   = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  logic              e_we;
  int                e_wl;
  logic [ADDR_W-1:0] e_a;
  logic [31:0]       e_d;

  always @(negedge clk) begin
    if (chk_en) begin
      e_we = 1'b0;
      e_wl = 0;
      e_a  = '0;
      e_d  = '0;
      foreach (exp_q[i]) begin
        if (exp_q[i].c <= cyc) begin
          e_wl++;
          e_a = exp_q[i].a;
          e_d = exp_q[i].d;
          if (exp_q[i].c == cyc) e_we = 1'b1;
        end
      end
      check("imem_we", imem_we, e_we);
      check("imem_waddr", imem_waddr, e_a);
      check("imem_wdata", imem_wdata, e_d);
      check("words_loaded", words_loaded, e_wl);
      check("load_done", load_done, cyc >= done_cyc);
      check("load_err", load_err, cyc >= err_cyc);
      check("core_hold", core_hold, !(cyc >= done_cyc));
      if (imem_we === 1'b1) obs.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    obs.delete();
    done_cyc = INF;
    err_cyc  = INF;
    chk_en   = 1'b1;
    #1 rst = 1'b0;
  endtask

  // Predict the whole stream from the byte list, then drive it with a fixed gap.
  task automatic run_stream(input int gap);
    int          c0;
    int          k;
    int          last;
    logic [31:0] n;
    bit          all_w;
    wr_t         w;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  x;
`endif
    c0    = cyc;
    all_w = 1'b1;
    if (stim.size() >= 4) begin
      n    = {stim[3], stim[2], stim[1], stim[0]};
      last = c0 + 3 * (gap + 1);
      if (n > 32'(MAX_WORDS)) begin
        err_cyc = last + 1;
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          k = 4 + 4 * i;
          if (k + 3 >= stim.size()) begin
            all_w = 1'b0;
            break;
          end
          w.c  = c0 + (k + 3) * (gap + 1) + 1;
          w.a  = ADDR_W'(BASE_ADDR + i);
          w.d  = {stim[k+3], stim[k+2], stim[k+1], stim[k]};
          last = c0 + (k + 3) * (gap + 1);
          exp_q.push_back(w);
        end
        if (all_w) begin
`ifdef LOADER_CHECKSUM_EN
          x = 8'h00;
          for (int j = 4; j < 4 + 4 * int'(n); j++) x = x ^ stim[j];
          k = 4 + 4 * int'(n);
          if (k < stim.size()) begin
            if (stim[k] == x) done_cyc = c0 + k * (gap + 1) + 1;
            else              err_cyc  = c0 + k * (gap + 1) + 1;
          end
`else
          done_cyc = (n == 32'd0) ? last + 1 : last + 2;
`endif
        end
      end
    end
    foreach (stim[j]) begin
      rx_data  = stim[j];
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Two-word image
    do_reset();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h90);
`endif
    run_stream(1);
    check("model_writes", exp_q.size(), 2);
    check("model_w0_data", exp_q[0].d, 32'h00000013);
    check("model_w1_addr", exp_q[1].a, 1);
    check("model_w1_data", exp_q[1].d, 32'h00100093);
`ifndef LOADER_CHECKSUM_EN
    check("model_done_after_w1", done_cyc, exp_q[1].c + 1);
`endif
    check("two_words_loaded", words_loaded, 2);
    check("two_words_done", load_done, 1);
    check("two_words_hold", core_hold, 0);
    check("two_words_we_count", obs.size(), 2);

    // Empty image
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    run_stream(0);
    check("empty_done", load_done, 1);
    check("empty_no_writes", obs.size(), 0);

    // Oversized header, trailing bytes ignored
    do_reset();
    stim = '{8'hEB, 8'h3F, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_stream(0);
    check("oversize_err", load_err, 1);
    check("oversize_hold", core_hold, 1);
    check("oversize_no_writes", obs.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    run_stream(0);
    check("csum_ok_done", load_done, 1);
    check("csum_ok_data", imem_wdata, 32'h08040201);
    do_reset();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    run_stream(0);
    check("csum_bad_err", load_err, 1);
    check("csum_bad_hold", core_hold, 1);
`else
    do_reset();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55, 8'h66, 8'h77, 8'h88};
    run_stream(2);
    check("single_data", imem_wdata, 32'hDEADBEEF);
    check("single_done", load_done, 1);
    check("single_extra_ignored", words_loaded, 1);
`endif

    // Reset in the middle of word 1, then a fresh one-word image
    do_reset();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_stream(0);
    check("midword_one_written", words_loaded, 1);
    do_reset();
    check("rst_words_loaded", words_loaded, 0);
    check("rst_waddr", imem_waddr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", core_hold, 1);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_stream(0);
    check("fresh_waddr", imem_waddr, 0);
    check("fresh_wdata", imem_wdata, 32'h12345678);
    check("fresh_we_count", obs.size(), 1);

    // Back-to-back bytes, three words
    do_reset();
    stim = '{8'h03, 8'h00, 8'h00, 8'h00,
             8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h03, 8'h00, 8'h00, 8'h00};
    run_stream(0);
    check("b2b_we_count", obs.size(), 3);
    if (obs.size() == 3) begin
      check("b2b_spacing_01", obs[1] - obs[0], 4);
      check("b2b_spacing_12", obs[2] - obs[1], 4);
    end
    check("b2b_last_addr", imem_waddr, 2);
    check("b2b_last_data", imem_wdata, 32'h00000003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
